// File: rtl/pass_checker.sv
`default_nettype none
// ============================================================================
// Module      : pass_checker
// Description : Compares a DIGITS-digit entered code against the stored code
//               once per rising edge of enb. A match opens the lock, which
//               relocks on request or after UNLOCK_CYC cycles. MAX_TRIES
//               consecutive mismatches enter a timed LOCKOUT with the alarm
//               raised.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               enb        - check request level; each 0->1 gives one compare
//               pass_in    - entered code (DIGITS*DIGIT_W bits)
//               pass_set   - stored code (DIGITS*DIGIT_W bits)
//               relock     - single-cycle close request while open
//               lock       - 1 = actuator released
//               led_RGB    - {R,G,B}: 100 closed, 010 open, 001 lockout
//               err        - one-cycle pulse per wrong compare
//               alarm      - high throughout lockout
//               tries_left - attempts remaining before lockout
//
// Options     : `define PASS_CHECKER_BLINK_EN makes the lockout LED blink
//               between 001 and 000 every BLINK_CYC cycles.
//
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pass_checker #(
    parameter int DIGITS      = 3,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int UNLOCK_CYC  = 500,
    parameter int BLINK_CYC   = 50
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enb,
    input  logic [DIGITS*DIGIT_W-1:0]          pass_in,
    input  logic [DIGITS*DIGIT_W-1:0]          pass_set,
    input  logic                               relock,
    output logic                               lock,
    output logic [2:0]                         led_RGB,
    output logic                               err,
    output logic                               alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int c_TRY_W = $clog2(MAX_TRIES + 1);
    localparam int c_UNL_W = (UNLOCK_CYC  > 0) ? $clog2(UNLOCK_CYC + 1)  : 1;
    localparam int c_LCK_W = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

    localparam logic [c_TRY_W-1:0] c_TRY_MAX = c_TRY_W'(MAX_TRIES);
    localparam logic [c_TRY_W-1:0] c_TRY_ONE = c_TRY_W'(1);
    localparam logic [c_UNL_W-1:0] c_UNL_LD  = c_UNL_W'(UNLOCK_CYC);
    localparam logic [c_UNL_W-1:0] c_UNL_ONE = c_UNL_W'(1);
    localparam logic [c_LCK_W-1:0] c_LCK_LD  = c_LCK_W'(LOCKOUT_CYC);
    localparam logic [c_LCK_W-1:0] c_LCK_ONE = c_LCK_W'(1);

    localparam logic [2:0] c_LED_CLOSED  = 3'b100;
    localparam logic [2:0] c_LED_OPEN    = 3'b010;
    localparam logic [2:0] c_LED_LOCKOUT = 3'b001;
    localparam logic [2:0] c_LED_DARK    = 3'b000;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_OPEN    = 2'd1;
    localparam logic [1:0] c_ST_LOCKOUT = 2'd2;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if (MAX_TRIES < 1) begin : g_bad_max_tries
        $error("pass_checker: MAX_TRIES must be at least 1");
    end
    if (BLINK_CYC < 1) begin : g_bad_blink_cyc
        $error("pass_checker: BLINK_CYC must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_enb_q;
    logic [c_UNL_W-1:0] r_unl_tmr;
    logic [c_LCK_W-1:0] r_lck_tmr;
    logic [c_TRY_W-1:0] r_tries_left;
    logic               r_lock;
    logic [2:0]         r_led;
    logic               r_err;
    logic               r_alarm;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic               w_rise;
    logic               w_match;
    logic [1:0]         w_state_nxt;
    logic [c_UNL_W-1:0] w_unl_nxt;
    logic [c_LCK_W-1:0] w_lck_nxt;
    logic [c_TRY_W-1:0] w_tries_nxt;
    logic               w_err_nxt;
    logic [2:0]         w_led_nxt;

    assign w_rise  = enb & ~r_enb_q;
    assign w_match = (pass_in == pass_set);

    always_comb begin
        w_state_nxt = r_state;
        w_unl_nxt   = r_unl_tmr;
        w_lck_nxt   = r_lck_tmr;
        w_tries_nxt = r_tries_left;
        w_err_nxt   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_rise) begin
                    if (w_match) begin
                        w_state_nxt = c_ST_OPEN;
                        w_tries_nxt = c_TRY_MAX;
                        w_unl_nxt   = c_UNL_LD;
                    end else begin
                        w_err_nxt = 1'b1;
                        // One attempt left means this miss exhausts the budget.
                        if (r_tries_left <= c_TRY_ONE) begin
                            w_state_nxt = c_ST_LOCKOUT;
                            w_tries_nxt = '0;
                            w_lck_nxt   = c_LCK_LD;
                        end else begin
                            w_tries_nxt = r_tries_left - c_TRY_ONE;
                        end
                    end
                end
            end

            c_ST_OPEN: begin
                // The timer holds the cycles of open time still owed,
                // including the current one; leaving when it shows 1 keeps
                // lock high for exactly UNLOCK_CYC cycles.
                if (relock) begin
                    w_state_nxt = c_ST_IDLE;
                    w_unl_nxt   = '0;
                end else if (UNLOCK_CYC != 0) begin
                    if (r_unl_tmr <= c_UNL_ONE) begin
                        w_state_nxt = c_ST_IDLE;
                        w_unl_nxt   = '0;
                    end else begin
                        w_unl_nxt = r_unl_tmr - c_UNL_ONE;
                    end
                end
            end

            c_ST_LOCKOUT: begin
                if (r_lck_tmr <= c_LCK_ONE) begin
                    w_state_nxt = c_ST_IDLE;
                    w_lck_nxt   = '0;
                    w_tries_nxt = c_TRY_MAX;
                end else begin
                    w_lck_nxt = r_lck_tmr - c_LCK_ONE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_unl_nxt   = '0;
                w_lck_nxt   = '0;
                w_tries_nxt = c_TRY_MAX;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // LED selection (optionally blinking during lockout)
    // ------------------------------------------------------------------------
`ifdef PASS_CHECKER_BLINK_EN
    localparam int c_BLK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_CYC - 1);

    logic [c_BLK_W-1:0] r_blk_cnt;
    logic               r_blk_dark;
    logic [c_BLK_W-1:0] w_blk_cnt_nxt;
    logic               w_blk_dark_nxt;

    // Counter and phase restart on every lockout entry so the LED always
    // begins lit; outside lockout both sit at zero.
    always_comb begin
        w_blk_cnt_nxt  = '0;
        w_blk_dark_nxt = 1'b0;
        if (r_state == c_ST_LOCKOUT && w_state_nxt == c_ST_LOCKOUT) begin
            if (r_blk_cnt == c_BLK_LAST) begin
                w_blk_cnt_nxt  = '0;
                w_blk_dark_nxt = ~r_blk_dark;
            end else begin
                w_blk_cnt_nxt  = r_blk_cnt + c_BLK_W'(1);
                w_blk_dark_nxt = r_blk_dark;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt  <= '0;
            r_blk_dark <= 1'b0;
        end else begin
            r_blk_cnt  <= w_blk_cnt_nxt;
            r_blk_dark <= w_blk_dark_nxt;
        end
    end

    always_comb begin
        w_led_nxt = c_LED_CLOSED;
        case (w_state_nxt)
            c_ST_OPEN:    w_led_nxt = c_LED_OPEN;
            c_ST_LOCKOUT: w_led_nxt = w_blk_dark_nxt ? c_LED_DARK : c_LED_LOCKOUT;
            default:      w_led_nxt = c_LED_CLOSED;
        endcase
    end
`else
    always_comb begin
        w_led_nxt = c_LED_CLOSED;
        case (w_state_nxt)
            c_ST_OPEN:    w_led_nxt = c_LED_OPEN;
            c_ST_LOCKOUT: w_led_nxt = c_LED_LOCKOUT;
            default:      w_led_nxt = c_LED_CLOSED;
        endcase
    end
`endif

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_enb_q      <= 1'b0;
            r_unl_tmr    <= '0;
            r_lck_tmr    <= '0;
            r_tries_left <= c_TRY_MAX;
            r_lock       <= 1'b0;
            r_led        <= c_LED_CLOSED;
            r_err        <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_enb_q      <= enb;
            r_unl_tmr    <= w_unl_nxt;
            r_lck_tmr    <= w_lck_nxt;
            r_tries_left <= w_tries_nxt;
            r_lock       <= (w_state_nxt == c_ST_OPEN);
            r_led        <= w_led_nxt;
            r_err        <= w_err_nxt;
            r_alarm      <= (w_state_nxt == c_ST_LOCKOUT);
        end
    end

    assign lock       = r_lock;
    assign led_RGB    = r_led;
    assign err        = r_err;
    assign alarm      = r_alarm;
    assign tries_left = r_tries_left;

endmodule
`default_nettype wire

// File: tb/tb_pass_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pass_checker
// Description : Self-checking bench for pass_checker. Directed scenarios are
//               followed by a randomized phase; every cycle is compared to a
//               reference model that tracks open/lockout windows as absolute
//               cycle deadlines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pass_checker;

    localparam int DIGITS      = 3;
    localparam int DIGIT_W     = 4;
    localparam int CW          = DIGITS * DIGIT_W;
    localparam int MAX_TRIES   = 3;
    localparam int LOCKOUT_CYC = 20;
    localparam int UNLOCK_CYC  = 10;
    localparam int BLINK_CYC   = 4;
    localparam int TW          = $clog2(MAX_TRIES + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic [CW-1:0] pass_in;
    logic [CW-1:0] pass_set;
    logic          relock;
    logic          lock;
    logic [2:0]    led_RGB;
    logic          err;
    logic          alarm;
    logic [TW-1:0] tries_left;

    pass_checker #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .MAX_TRIES   (MAX_TRIES),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .UNLOCK_CYC  (UNLOCK_CYC),
        .BLINK_CYC   (BLINK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .pass_in    (pass_in),
        .pass_set   (pass_set),
        .relock     (relock),
        .lock       (lock),
        .led_RGB    (led_RGB),
        .err        (err),
        .alarm      (alarm),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: state is expressed as time windows, not counters.
    int n          = 0;   // index of the last clock edge processed
    bit m_open     = 0;
    bit m_lockout  = 0;
    int open_exit  = 0;   // edge index at which OPEN ends on its own
    int lock_entry = 0;
    int lock_exit  = 0;
    int fails      = 0;
    bit m_err      = 0;
    bit enb_prev   = 0;

    // Observation tallies for scenario-level checks.
    int cnt_lock  = 0;
    int cnt_alarm = 0;
    int cnt_err   = 0;

    function automatic void model_reset();
        m_open    = 0;
        m_lockout = 0;
        fails     = 0;
        m_err     = 0;
        enb_prev  = 0;
    endfunction

    function automatic void model_edge();
        bit rise;
        rise = enb && !enb_prev;
        n++;
        m_err = 0;
        if (m_lockout) begin
            if (n == lock_exit) begin
                m_lockout = 0;
                fails     = 0;
            end
        end else if (m_open) begin
            if (relock || (UNLOCK_CYC != 0 && n == open_exit))
                m_open = 0;
        end else if (rise) begin
            if (pass_in == pass_set) begin
                m_open    = 1;
                fails     = 0;
                open_exit = n + UNLOCK_CYC;
            end else begin
                m_err = 1;
                fails++;
                if (fails == MAX_TRIES) begin
                    m_lockout  = 1;
                    lock_entry = n;
                    lock_exit  = n + LOCKOUT_CYC;
                end
            end
        end
        enb_prev = enb;
    endfunction

    function automatic logic [2:0] exp_led();
        if (m_lockout) begin
`ifdef PASS_CHECKER_BLINK_EN
            if (((n - lock_entry) / BLINK_CYC) % 2 == 1) return 3'b000;
`endif
            return 3'b001;
        end
        if (m_open) return 3'b010;
        return 3'b100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("lock",       32'(lock),       32'(m_open));
        check("led_RGB",    32'(led_RGB),    32'(exp_led()));
        check("err",        32'(err),        32'(m_err));
        check("alarm",      32'(alarm),      32'(m_lockout));
        check("tries_left", 32'(tries_left), 32'(m_lockout ? 0 : MAX_TRIES - fails));
    endtask

    // One clock: update the model with the inputs present at the edge, then
    // sample the DUT shortly after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
        cnt_lock  += int'(lock);
        cnt_alarm += int'(alarm);
        cnt_err   += int'(err);
    endtask

    task automatic clear_tallies();
        cnt_lock  = 0;
        cnt_alarm = 0;
        cnt_err   = 0;
    endtask

    // Single enb pulse (one cycle high, one low).
    task automatic pulse_enb(input logic [CW-1:0] code);
        pass_in = code;
        enb     = 1'b1;
        step();
        enb     = 1'b0;
        step();
    endtask

    // Asynchronous reset between edges, checked before the next clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_async_lock",  32'(lock),       32'd0);
        check("rst_async_alarm", 32'(alarm),      32'd0);
        check("rst_async_tries", 32'(tries_left), 32'(MAX_TRIES));
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        enb      = 1'b0;
        pass_in  = '0;
        pass_set = '0;
        relock   = 1'b0;

        // Reset state, visible before any clock edge.
        #2;
        check("reset_led",   32'(led_RGB),    32'h4);
        check("reset_tries", 32'(tries_left), 32'd3);
        check_all();
        step();
        step();
        rst = 1'b0;

        // Correct entry: lock held for exactly UNLOCK_CYC cycles.
        pass_set = 12'h5A3;
        clear_tallies();
        pass_in = 12'h5A3;
        enb     = 1'b1;
        step();
        check("open_lock",  32'(lock),       32'd1);
        check("open_led",   32'(led_RGB),    32'h2);
        check("open_tries", 32'(tries_left), 32'd3);
        enb = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("open_len",   32'(cnt_lock),   32'd10);
        check("open_end",   32'(led_RGB),    32'h4);

        // Three wrong codes -> lockout; a correct rise inside is ignored.
        clear_tallies();
        pulse_enb(12'h5A4);
        check("wrong1_tries", 32'(tries_left), 32'd2);
        pulse_enb(12'h5A4);
        check("wrong2_tries", 32'(tries_left), 32'd1);
        pulse_enb(12'h5A4);
        check("lock_alarm", 32'(alarm),      32'd1);
        check("lock_tries", 32'(tries_left), 32'd0);
        pulse_enb(12'h5A3);
        for (int i = 0; i < 22; i++) step();
        check("lock_errs",   32'(cnt_err),    32'd3);
        check("lock_len",    32'(cnt_alarm),  32'd20);
        check("lock_nolock", 32'(cnt_lock),   32'd0);
        check("lock_tries3", 32'(tries_left), 32'd3);

        // Two wrong, then correct clears the count; relock at open cycle 4.
        pulse_enb(12'h111);
        pulse_enb(12'h222);
        check("clr_tries1", 32'(tries_left), 32'd1);
        pass_in = 12'h5A3;
        enb     = 1'b1;
        step();
        enb = 1'b0;
        check("clr_tries3", 32'(tries_left), 32'd3);
        step();
        step();
        step();
        relock = 1'b1;
        step();
        relock = 1'b0;
        check("relock_lock", 32'(lock), 32'd0);
        step();

        // Level hold: one compare only.
        clear_tallies();
        pass_in = 12'h5A4;
        enb     = 1'b1;
        for (int i = 0; i < 15; i++) step();
        enb = 1'b0;
        step();
        check("hold_errs",  32'(cnt_err),    32'd1);
        check("hold_tries", 32'(tries_left), 32'd2);

        // Reset mid-lockout (cycle 7).
        pulse_enb(12'h001);
        enb = 1'b1;
        step();
        enb = 1'b0;
        for (int i = 0; i < 6; i++) step();
        async_reset();

        // Reset mid-open, then resume from IDLE.
        pass_in = 12'h5A3;
        enb     = 1'b1;
        step();
        enb = 1'b0;
        step();
        step();
        async_reset();
        clear_tallies();
        enb = 1'b1;
        step();
        enb = 1'b0;
        check("resume_lock", 32'(lock), 32'd1);

        // Relock coincident with timer expiry.
        for (int i = 0; i < 9; i++) step();
        relock = 1'b1;
        step();
        relock = 1'b0;
        check("coinc_len",  32'(cnt_lock), 32'd10);
        check("coinc_idle", 32'(led_RGB),  32'h4);
        step();
        step();

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) pass_set = CW'($urandom);
            enb     = 1'($urandom_range(0, 1));
            pass_in = ($urandom_range(0, 2) == 0) ? pass_set : CW'($urandom);
            relock  = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
